// File: rtl/alu_serial_if.sv
// Handshake and data bundle for alu_serial.
// The ovf signal exists only when ALU_SERIAL_OVF_EN is defined.
interface alu_serial_if #(parameter int unsigned WIDTH = 8);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [1:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             busy;
`ifdef ALU_SERIAL_OVF_EN
   logic             ovf;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result, cout, busy, ovf
   );
   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result, cout, busy, ovf
   );
`else
   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result, cout, busy
   );
   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result, cout, busy
   );
`endif
endinterface

// File: rtl/alu_serial.sv
// Bit-serial ALU (AND/OR/ADD/SUB), one result bit per cycle, LSB first.
// Optional signed-overflow output ovf enabled by macro ALU_SERIAL_OVF_EN.
module alu_serial #(
   parameter int unsigned WIDTH = 8
) (
   input logic         clk,
   input logic         rst_n,
   alu_serial_if.slave bus
);
   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_r, b_r, res_r;
   logic [1:0]       op_r;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             accept, last, arith, b_bit, sum_bit, carry_nx;

   assign accept = (state == IDLE) && bus.in_valid;
   assign last   = (cnt == CW'(WIDTH - 1));
   assign arith  = op_r[1];
   assign b_bit  = b_r[0] ^ (op_r == 2'b11);

   // Single 1-bit slice; operands are shifted right so bit 0 is always current
   always_comb begin
      sum_bit  = 1'b0;
      carry_nx = 1'b0;
      case (op_r)
         2'b00:   sum_bit = a_r[0] & b_r[0];
         2'b01:   sum_bit = a_r[0] | b_r[0];
         default: begin
            sum_bit  = a_r[0] ^ b_bit ^ carry;
            carry_nx = (a_r[0] & b_bit) | (carry & (a_r[0] ^ b_bit));
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx      = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_nx = RUN;
         end
         RUN: begin
            bus.busy = 1'b1;
            if (last) state_nx = DONE;
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r   <= '0;
         b_r   <= '0;
         op_r  <= '0;
         res_r <= '0;
         carry <= 1'b0;
         cnt   <= '0;
      end else if (accept) begin
         a_r   <= bus.a;
         b_r   <= bus.b;
         op_r  <= bus.op;
         carry <= (bus.op == 2'b11);
         cnt   <= '0;
      end else if (state == RUN) begin
         a_r   <= a_r >> 1;
         b_r   <= b_r >> 1;
         res_r <= {sum_bit, res_r[WIDTH-1:1]};
         carry <= carry_nx;
         cnt   <= cnt + CW'(1);
      end
   end

   assign bus.result = res_r;
   assign bus.cout   = carry;

`ifdef ALU_SERIAL_OVF_EN
   logic ovf_r;

   // At the MSB step, carry holds the carry into the MSB and carry_nx the carry out
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     ovf_r <= 1'b0;
      else if (accept)                ovf_r <= 1'b0;
      else if ((state == RUN) && last) ovf_r <= arith & (carry ^ carry_nx);
   end

   assign bus.ovf = ovf_r;
`endif
endmodule

// File: tb/tb_alu_serial.sv
// Directed scoreboard bench for alu_serial (WIDTH=8); checks ovf when ALU_SERIAL_OVF_EN is defined.
module tb_alu_serial;
   localparam int unsigned W = 8;

   typedef struct packed {
      logic [W-1:0] res;
      logic         c;
      logic         v;
   } exp_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   int unsigned nvec  = 0;
   int unsigned nfail = 0;
   exp_t        sb[$];

   alu_serial_if #(.WIDTH(W)) bus ();
   alu_serial #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] o);
      exp_t       e;
      logic [W:0] s;
      e = '0;
      s = '0;
      case (o)
         2'b00: e.res = x & y;
         2'b01: e.res = x | y;
         2'b10: begin
            s     = {1'b0, x} + {1'b0, y};
            e.res = s[W-1:0];
            e.c   = s[W];
            e.v   = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
         end
         default: begin
            s     = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
            e.res = s[W-1:0];
            e.c   = s[W];
            e.v   = (x[W-1] != y[W-1]) && (e.res[W-1] != x[W-1]);
         end
      endcase
      return e;
   endfunction

   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] o,
                         input int hold, input bit scramble);
      exp_t e;
      int   n;
      @(negedge clk);
      check("in_ready_idle", 32'(bus.in_ready), 32'd1);
      bus.a        = x;
      bus.b        = y;
      bus.op       = o;
      bus.in_valid = 1'b1;
      sb.push_back(model(x, y, o));
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("busy_run", 32'(bus.busy), 32'd1);
      check("in_ready_run", 32'(bus.in_ready), 32'd0);
      n = 0;
      while (!bus.out_valid && n < int'(3 * W)) begin
         if (scramble) begin
            bus.a        = W'($urandom);
            bus.b        = W'($urandom);
            bus.op       = 2'($urandom);
            bus.in_valid = 1'b1;
         end
         @(negedge clk);
         n++;
      end
      bus.in_valid = 1'b0;
      check("latency", 32'(n), 32'(W));
      e = sb.pop_front();
      for (int i = 0; i < hold; i++) begin
         check("hold_valid", 32'(bus.out_valid), 32'd1);
         check("hold_result", 32'(bus.result), 32'(e.res));
         check("hold_cout", 32'(bus.cout), 32'(e.c));
         check("hold_in_ready", 32'(bus.in_ready), 32'd0);
         @(negedge clk);
      end
      check("result", 32'(bus.result), 32'(e.res));
      check("cout", 32'(bus.cout), 32'(e.c));
      check("busy_done", 32'(bus.busy), 32'd0);
`ifdef ALU_SERIAL_OVF_EN
      check("ovf", 32'(bus.ovf), 32'(e.v));
`endif
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("in_ready_after", 32'(bus.in_ready), 32'd1);
      check("out_valid_after", 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      int seen;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.op        = '0;
      #12;
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_result", 32'(bus.result), 32'd0);
      check("rst_cout", 32'(bus.cout), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(8'h0F, 8'h01, 2'b10, 0, 1'b0);
      run_op(8'hFF, 8'h01, 2'b10, 0, 1'b0);
      run_op(8'h05, 8'h07, 2'b11, 0, 1'b0);
      run_op(8'h07, 8'h05, 2'b11, 0, 1'b0);
      run_op(8'hF0, 8'h3C, 2'b00, 0, 1'b0);
      run_op(8'hF0, 8'h3C, 2'b01, 0, 1'b0);
      run_op(8'hF0, 8'h3C, 2'b00, 0, 1'b1);
      run_op(8'hF0, 8'h3C, 2'b01, 0, 1'b1);
      run_op(8'h00, 8'h00, 2'b11, 0, 1'b0);
      run_op(8'hA5, 8'h5A, 2'b10, 5, 1'b0);
      run_op(8'h7F, 8'h01, 2'b10, 0, 1'b0);
      run_op(8'h80, 8'h01, 2'b11, 0, 1'b0);
      run_op(8'h01, 8'h01, 2'b10, 0, 1'b0);

      // Abort an ADD at bit 3 with an asynchronous reset pulse
      @(negedge clk);
      bus.a        = 8'hFF;
      bus.b        = 8'h01;
      bus.op       = 2'b10;
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_in_ready", 32'(bus.in_ready), 32'd1);
      check("abort_out_valid", 32'(bus.out_valid), 32'd0);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_result", 32'(bus.result), 32'd0);
      check("abort_cout", 32'(bus.cout), 32'd0);
`ifdef ALU_SERIAL_OVF_EN
      check("abort_ovf", 32'(bus.ovf), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < int'(W + 4); i++) begin
         @(negedge clk);
         if (bus.out_valid) seen++;
      end
      check("abort_no_output", 32'(seen), 32'd0);
      run_op(8'h01, 8'h01, 2'b10, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
